// File: rtl/bcd_ss_reader_if.sv
// Read-back handshake between the RTC register path and the BCD field reader.
// The master presents a packed BCD byte; the slave returns the binary value and status pulses.
interface bcd_ss_reader_if #(
    parameter int N = 6
);
    logic         rd_strobe;
    logic [7:0]   data_bcd;
    logic         ready;
    logic [N-1:0] bin_value;
    logic         done;
    logic         error;
    logic         changed;
    logic [7:0]   err_cnt;

    modport master (
        output rd_strobe, data_bcd,
        input  ready, bin_value, done, error, changed, err_cnt
    );

    modport slave (
        input  rd_strobe, data_bcd,
        output ready, bin_value, done, error, changed, err_cnt
    );
endinterface

// File: rtl/bcd_ss_reader.sv
// Validates a packed 2-digit BCD byte and converts it to binary (0..MAX_VAL).
// Holds the last good value; rejected bytes only bump a saturating error counter.
module bcd_ss_reader #(
    parameter int MAX_VAL = 59,
    parameter int N       = 6
) (
    input  logic             clk,
    input  logic             reset,
    bcd_ss_reader_if.slave   bus
);
    typedef enum logic [2:0] {IDLE, CHECK, CONV, COMMIT, REJECT} state_t;

    localparam logic [6:0] MAX_SUM = 7'(MAX_VAL);

    state_t       state;
    logic [3:0]   tens_r;
    logic [3:0]   units_r;
    logic [6:0]   sum_r;
    logic         digits_ok;

    logic         ready_r;
    logic [N-1:0] bin_r;
    logic         done_r;
    logic         error_r;
    logic         changed_r;
    logic [7:0]   err_cnt_r;

    // Only consumed in CONV, after both digits are known to be <= 9, so it never exceeds 99.
    assign sum_r     = ({3'b000, tens_r} << 3) + ({3'b000, tens_r} << 1) + {3'b000, units_r};
    assign digits_ok = (tens_r <= 4'd9) && (units_r <= 4'd9);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            tens_r    <= '0;
            units_r   <= '0;
            ready_r   <= 1'b1;
            bin_r     <= '0;
            done_r    <= 1'b0;
            error_r   <= 1'b0;
            changed_r <= 1'b0;
            err_cnt_r <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.rd_strobe) begin
                        tens_r  <= bus.data_bcd[7:4];
                        units_r <= bus.data_bcd[3:0];
                        ready_r <= 1'b0;
                        state   <= CHECK;
                    end
                end
                CHECK: begin
                    if (digits_ok) begin
                        state <= CONV;
                    end else begin
                        error_r   <= 1'b1;
                        err_cnt_r <= (err_cnt_r == 8'hFF) ? err_cnt_r : err_cnt_r + 8'd1;
                        state     <= REJECT;
                    end
                end
                CONV: begin
                    // Outputs are registered, so the result is loaded on the edge entering COMMIT.
                    if (sum_r > MAX_SUM) begin
                        error_r   <= 1'b1;
                        err_cnt_r <= (err_cnt_r == 8'hFF) ? err_cnt_r : err_cnt_r + 8'd1;
                        state     <= REJECT;
                    end else begin
                        bin_r     <= N'(sum_r);
                        done_r    <= 1'b1;
                        changed_r <= (N'(sum_r) != bin_r);
                        state     <= COMMIT;
                    end
                end
                COMMIT: begin
                    done_r    <= 1'b0;
                    changed_r <= 1'b0;
                    ready_r   <= 1'b1;
                    state     <= IDLE;
                end
                REJECT: begin
                    error_r <= 1'b0;
                    ready_r <= 1'b1;
                    state   <= IDLE;
                end
                default: begin
                    done_r    <= 1'b0;
                    error_r   <= 1'b0;
                    changed_r <= 1'b0;
                    ready_r   <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

    assign bus.ready     = ready_r;
    assign bus.bin_value = bin_r;
    assign bus.done      = done_r;
    assign bus.error     = error_r;
    assign bus.changed   = changed_r;
    assign bus.err_cnt   = err_cnt_r;
endmodule

// File: tb/tb_bcd_ss_reader.sv
// Scoreboard bench: seconds-field reader (MAX_VAL=59) and hours-field reader (MAX_VAL=23).
// Expected results are queued at the accept edge and matched against done/error pulses.
module tb_bcd_ss_reader;
    logic clk;
    logic reset;
    int   cyc;
    int   n_chk;
    int   n_fail;

    typedef struct {
        int is_err;
        int val;
        int chg;
        int ecnt;
        int acc;
        int lat;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   m_bin[2];
    int   m_err[2];
    int   rdy_pend0;
    int   rdy_pend1;

    bcd_ss_reader_if #(.N(6)) b0();
    bcd_ss_reader_if #(.N(5)) b1();

    bcd_ss_reader #(.MAX_VAL(59), .N(6)) u_sec (.clk(clk), .reset(reset), .bus(b0));
    bcd_ss_reader #(.MAX_VAL(23), .N(5)) u_hr  (.clk(clk), .reset(reset), .bus(b1));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: decimal digit decode, independent of the DUT's shift-add datapath.
    task automatic push_exp(input int d, input logic [7:0] b, input int acc);
        exp_t e;
        int   t, u, v, maxv;
        t    = int'(b[7:4]);
        u    = int'(b[3:0]);
        maxv = (d == 0) ? 59 : 23;
        e.acc = acc;
        e.chg = 0;
        if (t > 9 || u > 9) begin
            e.is_err = 1;
            e.lat    = 1;
        end else begin
            v = t * 10 + u;
            if (v > maxv) begin
                e.is_err = 1;
                e.lat    = 2;
            end else begin
                e.is_err = 0;
                e.lat    = 2;
                e.chg    = (v != m_bin[d]) ? 1 : 0;
                m_bin[d] = v;
            end
        end
        if (e.is_err != 0) m_err[d] = (m_err[d] < 255) ? m_err[d] + 1 : 255;
        e.val  = m_bin[d];
        e.ecnt = m_err[d];
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic send(input int d, input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk);
        while (((d == 0) ? b0.ready : b1.ready) !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("ready_timeout", 0, 1);
        if (d == 0) begin b0.data_bcd = b; b0.rd_strobe = 1'b1; end
        else        begin b1.data_bcd = b; b1.rd_strobe = 1'b1; end
        push_exp(d, b, cyc + 1);
        @(negedge clk);
        b0.rd_strobe = 1'b0;
        b1.rd_strobe = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && (q0.size() + q1.size()) != 0; i++) @(negedge clk);
        chk("drain", q0.size() + q1.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rdy_pend0 != 0) begin
            chk("ready_back0", b0.ready, 1);
            rdy_pend0 = 0;
        end
        if (b0.changed && !b0.done) chk("chg_wo_done0", 1, 0);
        if (b0.done || b0.error) begin
            chk("excl0", b0.done & b0.error, 0);
            if (q0.size() == 0) chk("unexpected0", 1, 0);
            else begin
                e = q0.pop_front();
                chk("kind0", b0.error, e.is_err);
                chk("val0", b0.bin_value, e.val);
                chk("chg0", b0.changed, e.chg);
                chk("ecnt0", b0.err_cnt, e.ecnt);
                chk("lat0", cyc - e.acc, e.lat);
                chk("busy0", b0.ready, 0);
                rdy_pend0 = 1;
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rdy_pend1 != 0) begin
            chk("ready_back1", b1.ready, 1);
            rdy_pend1 = 0;
        end
        if (b1.changed && !b1.done) chk("chg_wo_done1", 1, 0);
        if (b1.done || b1.error) begin
            chk("excl1", b1.done & b1.error, 0);
            if (q1.size() == 0) chk("unexpected1", 1, 0);
            else begin
                e = q1.pop_front();
                chk("kind1", b1.error, e.is_err);
                chk("val1", b1.bin_value, e.val);
                chk("chg1", b1.changed, e.chg);
                chk("ecnt1", b1.err_cnt, e.ecnt);
                chk("lat1", cyc - e.acc, e.lat);
                chk("busy1", b1.ready, 0);
                rdy_pend1 = 1;
            end
        end
    end

    initial begin
        logic [7:0] tbl [8];
        int last_acc;
        tbl = '{8'h12, 8'h34, 8'h56, 8'h07, 8'h41, 8'h29, 8'h50, 8'h18};
        clk = 1'b0; reset = 1'b0; cyc = 0; n_chk = 0; n_fail = 0;
        rdy_pend0 = 0; rdy_pend1 = 0;
        m_bin = '{0, 0}; m_err = '{0, 0};
        b0.rd_strobe = 1'b0; b0.data_bcd = '0;
        b1.rd_strobe = 1'b0; b1.data_bcd = '0;
        #1 reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ready", b0.ready, 1);
        chk("rst_bin", b0.bin_value, 0);
        chk("rst_done", b0.done, 0);
        chk("rst_err", b0.error, 0);
        chk("rst_chg", b0.changed, 0);
        chk("rst_ecnt", b0.err_cnt, 0);
        reset = 1'b0;

        send(0, 8'h37);
        drain();
        send(0, 8'h37);
        drain();
        chk("bin_37", b0.bin_value, 37);

        send(0, 8'h5A);
        send(0, 8'h60);
        send(0, 8'hF3);
        drain();
        chk("bin_kept", b0.bin_value, 37);
        chk("ecnt_3", b0.err_cnt, 3);

        send(0, 8'h59);
        send(0, 8'h99);
        send(0, 8'hA0);
        drain();
        chk("bin_59", b0.bin_value, 59);

        // Level-held strobe with data changing every cycle.
        last_acc = -1;
        for (int i = 0; i < 26; i++) begin
            @(negedge clk);
            b0.data_bcd  = tbl[i % 8];
            b0.rd_strobe = 1'b1;
            if (b0.ready) begin
                push_exp(0, tbl[i % 8], cyc + 1);
                if (last_acc >= 0) chk("period", cyc + 1 - last_acc, 4);
                last_acc = cyc + 1;
            end
        end
        @(negedge clk);
        b0.rd_strobe = 1'b0;
        drain();

        // Reset while CONV holds 0x45.
        b0.data_bcd = 8'h45;
        b0.rd_strobe = 1'b1;
        @(negedge clk);
        b0.rd_strobe = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk("mid_ready", b0.ready, 1);
        chk("mid_bin", b0.bin_value, 0);
        chk("mid_done", b0.done, 0);
        chk("mid_err", b0.error, 0);
        chk("mid_ecnt", b0.err_cnt, 0);
        m_bin = '{0, 0}; m_err = '{0, 0};
        @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        chk("mid_bin_after", b0.bin_value, 0);
        send(0, 8'h00);
        drain();

        send(1, 8'h23);
        send(1, 8'h24);
        drain();
        chk("hr_23", b1.bin_value, 23);
        for (int i = 0; i < 260; i++) send(1, (i % 2 == 0) ? 8'hAA : 8'h24);
        drain();
        chk("sat_255", b1.err_cnt, 255);
        chk("hr_kept", b1.bin_value, 23);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
